code_loader: RTL and testbench



---
 rtl/dibu_pkg.sv | 15 +
 rtl/code_loader.sv | 110 +++++++++++
 tb/tb_code_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/dibu_pkg.sv
// Shared types for the dibu boot path: loader states and the checksum constant.
package dibu_pkg;

  typedef enum logic [2:0] {
    ST_LEN,
    ST_HI,
    ST_LO,
    ST_SUM,
    ST_RUN,
    ST_ERR
  } loader_state_t;

  localparam logic [7:0] LOADER_SUM_OK = 8'h00;

endpackage

// File: rtl/code_loader.sv
// Boot loader: receives a LEN/data/SUM byte image, writes code words from address 0,
// and releases run only after the image checksum verifies.
//
// state | meaning
// LEN   | waiting for word-count byte (0 means 256 words)
// HI    | waiting for high byte of the current word
// LO    | waiting for low byte; accept schedules the memory write
// SUM   | waiting for checksum byte
// RUN   | image valid, datapath released
// ERR   | checksum mismatch, datapath held
module code_loader
  import dibu_pkg::*;
#(
  parameter int CODE_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              run,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr_in,
  output logic [CODE_W-1:0] code_in,
  output logic              err
);

  loader_state_t     state_q, state_d;
  logic [7:0]        len_q;
  logic [7:0]        words_q;
  logic [7:0]        sum_q;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic              w_en_q;
  logic [ADDR_W-1:0] w_addr_q;
  logic [CODE_W-1:0] w_data_q;

  logic       accept;
  logic       last_word;
  logic [7:0] sum_next;

  assign in_ready  = (state_q inside {ST_LEN, ST_HI, ST_LO, ST_SUM}) && !load_req;
  assign accept    = in_valid && in_ready;
  assign sum_next  = sum_q + in_data;
  // 8-bit wrap makes LEN=0 terminate after the 256th word
  assign last_word = (words_q + 8'd1) == len_q;

  assign run          = (state_q == ST_RUN);
  assign err          = (state_q == ST_ERR);
  assign code_w_en    = w_en_q;
  assign code_addr_in = w_addr_q;
  assign code_in      = w_data_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LEN: if (accept) state_d = ST_HI;
      ST_HI:  if (accept) state_d = ST_LO;
      ST_LO:  if (accept) state_d = last_word ? ST_SUM : ST_HI;
      ST_SUM: if (accept) state_d = (sum_next == LOADER_SUM_OK) ? ST_RUN : ST_ERR;
      ST_RUN: state_d = ST_RUN;
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_LEN;
    endcase
    if (load_req) state_d = ST_LEN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LEN;
      len_q    <= '0;
      words_q  <= '0;
      sum_q    <= '0;
      hi_q     <= '0;
      addr_q   <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      state_q <= state_d;
      w_en_q  <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_LEN: begin
            len_q   <= in_data;
            sum_q   <= in_data;
            addr_q  <= '0;
            words_q <= '0;
          end
          ST_HI: begin
            hi_q  <= in_data;
            sum_q <= sum_next;
          end
          ST_LO: begin
            sum_q    <= sum_next;
            w_en_q   <= 1'b1;
            w_addr_q <= addr_q;
            w_data_q <= CODE_W'({hi_q, in_data});
            addr_q   <= addr_q + 1'b1;
            words_q  <= words_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_code_loader.sv
// Directed bench for code_loader: image table plus abort, reset and 256-word sequences.
module tb_code_loader;
  import dibu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        run;
  logic        code_w_en;
  logic [7:0]  code_addr_in;
  logic [15:0] code_in;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [23:0] wq[$];

  code_loader #(.CODE_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .run(run), .code_w_en(code_w_en),
    .code_addr_in(code_addr_in), .code_in(code_in), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (code_w_en) wq.push_back({code_addr_in, code_in});

  typedef struct {
    logic [0:7][7:0]  b;
    int               n;
    int               gap;
    int               nw;
    logic [0:2][7:0]  wa;
    logic [0:2][15:0] wd;
    logic             exp_run;
    logic             exp_err;
  } img_t;

  img_t imgs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    in_valid = 1'b0;
    #1 chk("ready_during_load_req", in_ready, 0);
    @(negedge clk);
    load_req = 1'b0;
    chk("run_after_load_req", run, 0);
    chk("err_after_load_req", err, 0);
    chk("wen_after_load_req", code_w_en, 0);
    #1 chk("ready_after_load_req", in_ready, 1);
  endtask

  task automatic check_writes(input string name, input int nw,
                              input logic [0:2][7:0] wa, input logic [0:2][15:0] wd);
    repeat (2) @(negedge clk);
    chk({name, "_nwrites"}, wq.size(), nw);
    for (int i = 0; i < nw && i < wq.size(); i++)
      chk({name, "_write"}, wq[i], {wa[i], wd[i]});
  endtask

  initial begin
    logic [0:2][7:0]  wa;
    logic [0:2][15:0] wd;
    logic [7:0]       gaps;

    imgs[0] = '{b: {8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEA, 8'h00, 8'h00}, n: 6, gap: 0,
                nw: 2, wa: {8'd0, 8'd1, 8'd0}, wd: {16'h1234, 16'h5678, 16'h0},
                exp_run: 1'b1, exp_err: 1'b0};
    imgs[1] = '{b: {8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h8C, 8'h00, 8'h00}, n: 6, gap: 0,
                nw: 2, wa: {8'd0, 8'd1, 8'd0}, wd: {16'h1234, 16'h5678, 16'h0},
                exp_run: 1'b0, exp_err: 1'b1};
    imgs[2] = '{b: {8'h01, 8'hAB, 8'hCD, 8'h87, 8'h00, 8'h00, 8'h00, 8'h00}, n: 4, gap: 2,
                nw: 1, wa: {8'd0, 8'd0, 8'd0}, wd: {16'hABCD, 16'h0, 16'h0},
                exp_run: 1'b1, exp_err: 1'b0};
    imgs[3] = '{b: {8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'hFC}, n: 8, gap: 3,
                nw: 3, wa: {8'd0, 8'd1, 8'd2}, wd: {16'h0001, 16'h0002, 16'hFFFF},
                exp_run: 1'b1, exp_err: 1'b0};

    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_run", run, 0);
    chk("rst_err", err, 0);
    chk("rst_wen", code_w_en, 0);
    chk("rst_addr", code_addr_in, 0);
    chk("rst_code", code_in, 0);
    rst = 1'b0;
    #1 chk("rst_ready", in_ready, 1);

    for (int k = 0; k < 4; k++) begin
      wq.delete();
      for (int i = 0; i < imgs[k].n; i++) send_byte(imgs[k].b[i], imgs[k].gap);
      @(negedge clk);
      in_valid = 1'b0;
      chk("img_run", run, imgs[k].exp_run);
      chk("img_err", err, imgs[k].exp_err);
      chk("img_ready_done", in_ready, 0);
      check_writes("img", imgs[k].nw, imgs[k].wa, imgs[k].wd);
      chk("img_run_held", run, imgs[k].exp_run);
      pulse_load();
    end

    // 256-word image, word i = i, checksum 0x80
    wq.delete();
    send_byte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00, 0);
      send_byte(i[7:0], 0);
    end
    send_byte(8'h80, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("big_run", run, 1);
    chk("big_err", err, 0);
    repeat (2) @(negedge clk);
    chk("big_nwrites", wq.size(), 256);
    for (int i = 0; i < 256 && i < wq.size(); i++)
      chk("big_write", wq[i], {i[7:0], 8'h00, i[7:0]});
    pulse_load();

    // abort after HI byte of word 1; the byte offered with load_req is dropped
    wq.delete();
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
    @(negedge clk);
    load_req = 1'b1; in_valid = 1'b1; in_data = 8'h78;
    #1 chk("abort_ready", in_ready, 0);
    @(negedge clk);
    load_req = 1'b0; in_valid = 1'b0;
    chk("abort_run", run, 0);
    #1 chk("abort_ready_after", in_ready, 1);
    send_byte(8'h01, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0); send_byte(8'h87, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_reload_run", run, 1);
    wa = {8'd0, 8'd0, 8'd0};
    wd = {16'h1234, 16'hABCD, 16'h0};
    check_writes("abort", 2, wa, wd);
    pulse_load();

    // reset mid-image, then a full image with 0..3 idle cycles between bytes
    send_byte(8'h02, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wen", code_w_en, 0);
    chk("midrst_addr", code_addr_in, 0);
    chk("midrst_code", code_in, 0);
    chk("midrst_run", run, 0);
    chk("midrst_err", err, 0);
    rst = 1'b0;
    #1 chk("midrst_ready", in_ready, 1);
    wq.delete();
    for (int i = 0; i < 6; i++) begin
      gaps = imgs[0].b[i];
      send_byte(gaps, i % 4);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("gap_run", run, 1);
    chk("gap_err", err, 0);
    check_writes("gap", imgs[0].nw, imgs[0].wa, imgs[0].wd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
